// File: rtl/grf_multiport.sv
// grf_multiport: general register file with NUM_RD combinational read ports, one write port,
// same-cycle write-to-read bypass, optional hardwired-zero r0, per-register pending scoreboard
// and a one-register-per-cycle clear engine.
// Latency: reads are combinational, writes land at the rising edge, and the clear takes DEPTH cycles.
// Backpressure: there is no handshake. While ClrBusy is high, writes, marks and ClrReq are dropped,
// so the caller must stall.
//
// Ports:
//   Clk, Reset (async active-low)
//   RdAddr/RdData/RdPend : packed per-port read address / data / pending-hazard flag
//   WrEn/WrAddr/WrData   : write port (from writeback); WPC is the writer's PC, trace only
//   MarkEn/MarkAddr      : set the pending bit of a destination register
//   ClrReq/ClrBusy       : start / status of the clear engine
// Build option: define GRF_TRACE_EN to print every committed write.
module grf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdPend,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [31:0]              WPC,
  input  logic                     MarkEn,
  input  logic [ADDR_W-1:0]        MarkAddr,
  input  logic                     ClrReq,
  output logic                     ClrBusy
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam bit              HAS_ZERO   = (ZERO_REG != 0);
  localparam logic [ADDR_W:0] IDX_LAST   = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_idx;     // one spare bit so the last-index compare never wraps
  logic                r_clr_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_pend;

  logic w_idle;
  logic w_wr_commit;
  logic w_mark;

  assign w_idle      = (r_state == S_IDLE);
  // r0 is never written and never marked when it is hardwired to zero.
  assign w_wr_commit = WrEn   && w_idle && !(HAS_ZERO && (WrAddr   == '0));
  assign w_mark      = MarkEn && w_idle && !(HAS_ZERO && (MarkAddr == '0));
  assign ClrBusy     = r_clr_busy;

  // Read ports. The bypass uses w_wr_commit so dropped writes never leak into reads.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    logic              w_zero;

    assign w_addr = RdAddr[g*ADDR_W +: ADDR_W];
    assign w_hit  = w_wr_commit && (WrAddr == w_addr);
    assign w_zero = HAS_ZERO && (w_addr == '0);

    assign RdData[g*DATA_W +: DATA_W] = w_zero ? '0 : (w_hit ? WrData : r_mem[w_addr]);
    // A write landing this cycle resolves the hazard for the reader right away.
    assign RdPend[g] = r_pend[w_addr] & ~w_hit;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_clr_busy <= 1'b0;
      r_pend     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // A write that arrives with ClrReq still commits; the sweep then zeroes it.
          if (w_wr_commit) begin
            r_mem[WrAddr] <= WrData;
          end
          if (ClrReq) begin
            r_state    <= S_CLEAR;
            r_idx      <= '0;
            r_clr_busy <= 1'b1;
            r_pend     <= '0;
          end else begin
            if (w_wr_commit) begin
              r_pend[WrAddr] <= 1'b0;
            end
            // The mark comes after the clear so that a mark and a write to the same register leave it pending.
            if (w_mark) begin
              r_pend[MarkAddr] <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_mem[r_idx[ADDR_W-1:0]] <= '0;
          r_idx                    <= r_idx + (ADDR_W + 1)'(1);
          if (r_idx == IDX_LAST) begin
            r_state    <= S_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRF_TRACE_EN
  always @(posedge Clk) begin
    if (Reset && w_wr_commit) begin
      $display("@%h: $%d <= %h", WPC, WrAddr, WrData);
    end
  end
`else
  logic w_unused_wpc;
  assign w_unused_wpc = ^WPC;
`endif

endmodule
